// File: rtl/ball_motion_pkg.sv
// ball_motion_pkg: shared encodings and grid constants for the ball motion block.
package ball_motion_pkg;

    typedef enum logic [1:0] {DIR_UL, DIR_UR, DIR_DL, DIR_DR} dir_t;
    typedef enum logic [1:0] {IDLE, MOVE, LOST, OVER} state_t;

    localparam logic [3:0] GRID_MAX   = 4'd15;
    localparam logic [3:0] PADDLE_ROW = 4'd15;
    localparam logic [3:0] BRICK_ROWS = 4'd7;

endpackage

// File: rtl/ball_step.sv
// ball_step: one-tick combinational ball move with wall, brick and paddle bounces.
module ball_step
    import ball_motion_pkg::*;
#(
    parameter int PADDLE_W = 4
) (
    input  logic [3:0]  row,
    input  logic [3:0]  col,
    input  logic [1:0]  dir,
    input  logic [55:0] bricks,
    input  logic [3:0]  paddle_col,
    output logic [3:0]  row_next,
    output logic [3:0]  col_next,
    output logic [1:0]  dir_next,
    output logic        miss
);
    localparam logic [3:0] PAD_SPAN = 4'(PADDLE_W - 1);

    logic       h_flip, right, down, top, brick, at_paddle, overlap, hit;
    logic [3:0] row_step;
    logic [2:0] brick_row;
    logic [5:0] brick_idx;

    assign h_flip   = dir[0] ? (col == GRID_MAX) : (col == 4'd0);
    assign right    = dir[0] ^ h_flip;
    assign col_next = right ? col + 4'd1 : col - 4'd1;

    assign down     = dir[1];
    assign row_step = down ? row + 4'd1 : row - 4'd1;
    assign top      = !down && row == 4'd0;

    // Bricks are checked at the cell the ball is about to enter
    assign brick_row = row_step[2:0] - 3'd1;
    assign brick_idx = {brick_row, col_next[3:1]};
    assign brick     = !top && row_step != 4'd0 && row_step <= BRICK_ROWS && bricks[brick_idx];

    assign at_paddle = down && row == PADDLE_ROW - 4'd1;
    assign overlap   = col_next >= paddle_col && col_next <= paddle_col + PAD_SPAN;
    assign hit       = at_paddle && overlap;
    assign miss      = at_paddle && !overlap;

    assign row_next = top ? 4'd1 : (brick || hit) ? row : row_step;
    assign dir_next = {down ^ (top || brick || hit), right};

endmodule

// File: rtl/ball_motion.sv
// ball_motion: ball position/direction FSM for a brick-breaker game, stepping on tick.
module ball_motion
    import ball_motion_pkg::*;
#(
    parameter int LIVES_INIT = 3,
    parameter int PADDLE_W   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic [3:0]  paddle_col,
    input  logic [55:0] Bricks,
    output logic [3:0]  Ball_rowIndex,
    output logic [3:0]  Ball_colIndex,
    output logic [1:0]  Ball_direction,
    output logic [2:0]  lives,
    output logic        game_over
);
    localparam logic [3:0] PAD_MAX = 4'(16 - PADDLE_W);

    state_t     state, state_next;
    logic       lost_tick;
    logic       miss;
    logic [3:0] pad, row_next, col_next;
    logic [1:0] dir_next;

    assign pad = paddle_col > PAD_MAX ? PAD_MAX : paddle_col;

    ball_step #(.PADDLE_W(PADDLE_W)) u_step (
        .row        (Ball_rowIndex),
        .col        (Ball_colIndex),
        .dir        (Ball_direction),
        .bricks     (Bricks),
        .paddle_col (pad),
        .row_next   (row_next),
        .col_next   (col_next),
        .dir_next   (dir_next),
        .miss       (miss)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? MOVE : IDLE;
            MOVE:    state_next = (tick && miss) ? LOST : MOVE;
            LOST:    state_next = (tick && lost_tick) ? (lives != 3'd0 ? IDLE : OVER) : LOST;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            Ball_rowIndex  <= PADDLE_ROW - 4'd1;
            Ball_colIndex  <= 4'd1;
            Ball_direction <= DIR_UR;
            lives          <= 3'(LIVES_INIT);
            lost_tick      <= 1'b0;
            game_over      <= 1'b0;
        end else begin
            state     <= state_next;
            game_over <= state_next == OVER;
            if (state == IDLE) begin
                Ball_rowIndex  <= PADDLE_ROW - 4'd1;
                Ball_colIndex  <= pad + 4'd1;
                Ball_direction <= DIR_UR;
                lost_tick      <= 1'b0;
            end
            if (state == MOVE && tick) begin
                Ball_rowIndex  <= row_next;
                Ball_colIndex  <= col_next;
                Ball_direction <= dir_next;
                lives          <= lives - {2'b00, miss};
            end
            // first tick in LOST arms the return on the second
            if (state == LOST && tick)
                lost_tick <= 1'b1;
        end
    end

endmodule

// File: doc/ball_motion.md
BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 Parameter LIVES_INIT, default 3, balls granted per game (1..7).
REQ-002 Parameter PADDLE_W, default 4, paddle width in columns.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 tick  input  1  one-cycle move-enable pulse (2 Hz game rate).
REQ-006 start  input  1  level or pulse; launches ball from IDLE.
REQ-007 paddle_col  input  4  leftmost paddle column, row 15; values above 16-PADDLE_W are clamped to 16-PADDLE_W.
REQ-008 Bricks  input  56  brick map; bit (r-1)*8+(c>>1) set means a brick occupies row r (1..7), columns c and c^1.
REQ-009 Ball_rowIndex  output  4  ball row, 0 = top.
REQ-010 Ball_colIndex  output  4  ball column, 0 = left.
REQ-011 Ball_direction  output  2  bit1: 0 up / 1 down; bit0: 0 left / 1 right (00 UL, 01 UR, 10 DL, 11 DR).
REQ-012 lives  output  3  remaining balls.
REQ-013 game_over  output  1  high while in state OVER.

Function
REQ-014 FSM states SHALL be IDLE, MOVE, LOST, OVER; all outputs registered.
REQ-015 IDLE: every cycle row=14, col=clamped paddle_col+1, direction=01; start=1 -> MOVE next cycle.
REQ-016 MOVE: position/direction update only on cycles with tick=1; tick ignored in all other states.
REQ-017 Horizontal step first: col_next=col+-1 per bit0; at col 0 moving left or col 15 moving right, flip bit0 and col_next=col+-1 in the new direction.
REQ-018 Vertical step using col_next: row_next=row+-1 per bit1.
REQ-019 Top wall: row 0 moving up -> flip bit1, row_next=1.
REQ-020 Brick: row_next in 1..7 and brick bit for (row_next, col_next) set -> flip bit1, row unchanged, col_next applied; horizontal and brick flips in one tick are both applied.
REQ-021 Paddle: row 14 moving down and paddle_col<=col_next<=paddle_col+PADDLE_W-1 -> flip bit1, row stays 14.
REQ-022 Miss: row 14 moving down without paddle overlap -> row 15, lives decrement, state LOST.
REQ-023 LOST: after 2 ticks -> IDLE if lives>0, else OVER.
REQ-024 OVER: outputs frozen, game_over=1; only reset exits.
REQ-025 start asserted outside IDLE SHALL have no effect.
REQ-026 Bricks SHALL be sampled only on tick cycles in MOVE; brick clearing by the downstream scorer is not this block's concern.
REQ-027 All arithmetic 4-bit unsigned; no wrap-around ever reaches outputs because wall rules pre-empt it.

Reset
REQ-028 On reset=1 at a clock edge: state IDLE, row 14, col 1, direction 01, lives=LIVES_INIT, game_over 0; reset overrides tick/start in the same cycle.
REQ-029 Reset mid-MOVE or mid-LOST SHALL abandon the ball with no lives change beyond the reset value.

Structure
REQ-030 Shared package holds direction encodings, state enum, GRID_MAX=15, PADDLE_ROW=15, BRICK_ROWS=7.
REQ-031 One combinational sub-module ball_step SHALL compute row_next, col_next, dir_next, miss from current position, Bricks, paddle_col.

Verification
REQ-032 Reset, paddle_col=5 -> row 14, col 6, dir 01, lives 3 one cycle after reset release.
REQ-033 Ball at (0,9) dir 01, tick -> (1,10) dir 11.
REQ-034 Ball at (5,15) dir 01, tick -> col 14, row 4, dir 00; same with brick at (4,14) set -> (5,14) dir 10.
REQ-035 Ball (14,8) dir 11, paddle_col 7, tick -> (14,9) dir 01; paddle_col 12 -> row 15, lives 2, LOST, IDLE after 2 ticks.
REQ-036 LIVES_INIT=1, miss -> OVER after 2 ticks, game_over 1, start ignored until reset.
REQ-037 tick and reset in same cycle during MOVE -> reset values, no movement.
